// File: rtl/camera_dummy_pkg.sv
// Shared definitions for the camera stand-in.
//   cam_state_e : control FSM states (IDLE / BURST / WAIT)
//   LED_ON      : drive level that lights a board LED (LEDs are active-low)
//   led_drive() : maps "indicator active" to the LED pin level
package camera_dummy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_WAIT  = 2'd2
    } cam_state_e;

    localparam logic LED_ON = 1'b0;

    function automatic logic led_drive(input logic active);
        return active ? LED_ON : ~LED_ON;
    endfunction

endpackage

// File: rtl/sclk_activity_det.sv
// SCLK activity detector.
// Synchronises the free-running host SPI clock into the CLK domain and reports
// burst activity.
//   CLK  in  : core clock
//   RST  in  : synchronous active-low reset
//   SCLK in  : host SPI clock straight from the pin (asynchronous)
//   BUSY out : burst in progress, registered
//   RISE out : single-cycle strobe, BUSY goes high at the next CLK edge
//   FALL out : single-cycle strobe, BUSY goes low at the next CLK edge
// RISE/FALL are decoded from registers so the consumer can act on the same edge
// at which BUSY changes.
module sclk_activity_det #(
    parameter int IDLE_CYC = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    output logic BUSY,
    output logic RISE,
    output logic FALL
);

    localparam int ICW = $clog2(IDLE_CYC + 1);

    logic           sclk_meta_r;
    logic           sclk_sync_r;
    logic           sclk_prev_r;
    logic [2:0]     vld_r;
    logic [ICW-1:0] idle_cnt_r;
    logic           busy_r;
    logic           edge_s;
    logic           rise_s;
    logic           fall_s;

    // Two-flop synchroniser, history flop and pipeline-valid shift register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            vld_r       <= 3'b000;
        end else begin
            sclk_meta_r <= SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            vld_r       <= {vld_r[1:0], 1'b1};
        end
    end

    // Edge decode; masked until the synchroniser holds real pin samples so a
    // pin resting high at reset release is not mistaken for activity.
    always_comb begin
        edge_s = (sclk_sync_r ^ sclk_prev_r) & vld_r[2];
        rise_s = edge_s & ~busy_r;
        fall_s = ~edge_s & busy_r & (idle_cnt_r == ICW'(IDLE_CYC - 1));
    end

    // Idle counter and BUSY flag: every edge reloads, IDLE_CYC quiet cycles end the burst.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            idle_cnt_r <= {ICW{1'b0}};
            busy_r     <= 1'b0;
        end else if (edge_s) begin
            idle_cnt_r <= {ICW{1'b0}};
            busy_r     <= 1'b1;
        end else if (busy_r) begin
            idle_cnt_r <= idle_cnt_r + ICW'(1);
            busy_r     <= ~fall_s;
        end else begin
            idle_cnt_r <= idle_cnt_r;
            busy_r     <= busy_r;
        end
    end

    assign BUSY = busy_r;
    assign RISE = rise_s;
    assign FALL = fall_s;

endmodule

// File: rtl/camera_phase_dummy.sv
// Camera stand-in for host bring-up.
// When an SCLK burst ends the next lookup phase is published on LOOKUP, and INT
// is raised DELAY_CYC cycles later. A burst starting while INT is still pending
// aborts it and sets the sticky OVERRUN flag.
//   CLK       in  : core clock
//   RST       in  : synchronous active-low reset
//   SCLK      in  : host SPI clock (asynchronous)
//   CLR_OVR   in  : clears OVERRUN (a simultaneous set wins)
//   INT       out : interrupt, level or 1-cycle pulse (INT_PULSE)
//   LOOKUP    out : current phase index
//   BUSY      out : SPI burst in progress
//   OVERRUN   out : sticky abort flag
//   FRAME_CNT out : INTs issued, wraps
//   LED_R/G/B out : active-low mirrors of INT, |LOOKUP, BUSY
module camera_phase_dummy
    import camera_dummy_pkg::*;
#(
    parameter  int NUM_PHASES = 2,
    parameter  int IDLE_CYC   = 64,
    parameter  int DELAY_CYC  = 239980,
    parameter  int CNT_W      = 32,
    parameter  int INT_PULSE  = 0,
    parameter  int FCW        = 16,
    localparam int PW         = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           SCLK,
    input  logic           CLR_OVR,
    output logic           INT,
    output logic [PW-1:0]  LOOKUP,
    output logic           BUSY,
    output logic           OVERRUN,
    output logic [FCW-1:0] FRAME_CNT,
    output logic           LED_R,
    output logic           LED_G,
    output logic           LED_B
);

    cam_state_e     state_r;
    cam_state_e     state_nxt_s;
    logic           busy_s;
    logic           rise_s;
    logic           fall_s;
    logic           delay_done_s;
    logic           int_fire_s;
    logic           ovr_set_s;
    logic [CNT_W-1:0] dly_cnt_r;
    logic           int_r;
    logic [PW-1:0]  lookup_r;
    logic [PW-1:0]  phase_next_r;
    logic           ovr_r;
    logic [FCW-1:0] frame_r;

    sclk_activity_det #(
        .IDLE_CYC (IDLE_CYC)
    ) u_det (
        .CLK  (CLK),
        .RST  (RST),
        .SCLK (SCLK),
        .BUSY (busy_s),
        .RISE (rise_s),
        .FALL (fall_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode; a new burst always takes priority over delay completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) state_nxt_s = ST_BURST;
                else        state_nxt_s = ST_IDLE;
            end
            ST_BURST: begin
                if (fall_s) state_nxt_s = ST_WAIT;
                else        state_nxt_s = ST_BURST;
            end
            ST_WAIT: begin
                if (rise_s)            state_nxt_s = ST_BURST;
                else if (delay_done_s) state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_WAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output strobes.
    always_comb begin
        delay_done_s = (state_r == ST_WAIT) && (dly_cnt_r == CNT_W'(DELAY_CYC - 1));
        int_fire_s   = delay_done_s && !rise_s;
        ovr_set_s    = rise_s && (state_r == ST_WAIT);
    end

    // Phase sequencing: advance on burst start, publish on burst end.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lookup_r     <= {PW{1'b0}};
            phase_next_r <= {PW{1'b0}};
        end else if (rise_s) begin
            lookup_r     <= {PW{1'b0}};
            phase_next_r <= (phase_next_r == PW'(NUM_PHASES - 1)) ? {PW{1'b0}}
                                                                  : phase_next_r + PW'(1);
        end else if (fall_s) begin
            lookup_r     <= phase_next_r;
            phase_next_r <= phase_next_r;
        end else begin
            lookup_r     <= lookup_r;
            phase_next_r <= phase_next_r;
        end
    end

    // INT delay counter; stops at DELAY_CYC-1 because the FSM leaves WAIT there.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dly_cnt_r <= {CNT_W{1'b0}};
        end else if (fall_s) begin
            dly_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !delay_done_s) begin
            dly_cnt_r <= dly_cnt_r + CNT_W'(1);
        end else begin
            dly_cnt_r <= dly_cnt_r;
        end
    end

    // INT and frame counter; INT is cleared by any burst start.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            int_r   <= 1'b0;
            frame_r <= {FCW{1'b0}};
        end else if (rise_s) begin
            int_r   <= 1'b0;
            frame_r <= frame_r;
        end else if (int_fire_s) begin
            int_r   <= 1'b1;
            frame_r <= frame_r + FCW'(1);
        end else if (INT_PULSE != 0) begin
            int_r   <= 1'b0;
            frame_r <= frame_r;
        end else begin
            int_r   <= int_r;
            frame_r <= frame_r;
        end
    end

    // Sticky overrun flag; a set in the same cycle as CLR_OVR wins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ovr_r <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_r <= 1'b1;
        end else if (CLR_OVR) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign INT       = int_r;
    assign LOOKUP    = lookup_r;
    assign BUSY      = busy_s;
    assign OVERRUN   = ovr_r;
    assign FRAME_CNT = frame_r;
    assign LED_R     = led_drive(int_r);
    assign LED_G     = led_drive(|lookup_r);
    assign LED_B     = led_drive(busy_s);

endmodule

// File: tb/tb_camera_phase_dummy.sv
// Self-checking bench for camera_phase_dummy.
// Instance A: NUM_PHASES=4, level INT, 16-bit frame counter.
// Instance B: NUM_PHASES=2, pulse INT, 2-bit frame counter.
// Expected timing is derived from the behavioural rules: BUSY appears 3 CLK
// after an SCLK transition, LOOKUP updates IDLE_CYC cycles after the last edge
// is seen (3+IDLE_CYC after the last pin transition) and INT rises DELAY_CYC
// cycles after that.
module tb_camera_phase_dummy;

    localparam int IDLE  = 64;
    localparam int DELAY = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, sclk_a, clr_a, int_a, busy_a, ovr_a, ledr_a, ledg_a, ledb_a;
    logic [1:0]  lookup_a;
    logic [15:0] frame_a;
    logic        rst_b, sclk_b, clr_b, int_b, busy_b, ovr_b, ledr_b, ledg_b, ledb_b;
    logic [0:0]  lookup_b;
    logic [1:0]  frame_b;

    camera_phase_dummy #(.NUM_PHASES(4), .IDLE_CYC(IDLE), .DELAY_CYC(DELAY),
                         .CNT_W(16), .INT_PULSE(0), .FCW(16)) dut_a (
        .CLK(clk), .RST(rst_a), .SCLK(sclk_a), .CLR_OVR(clr_a), .INT(int_a),
        .LOOKUP(lookup_a), .BUSY(busy_a), .OVERRUN(ovr_a), .FRAME_CNT(frame_a),
        .LED_R(ledr_a), .LED_G(ledg_a), .LED_B(ledb_a));

    camera_phase_dummy #(.NUM_PHASES(2), .IDLE_CYC(IDLE), .DELAY_CYC(DELAY),
                         .CNT_W(16), .INT_PULSE(1), .FCW(2)) dut_b (
        .CLK(clk), .RST(rst_b), .SCLK(sclk_b), .CLR_OVR(clr_b), .INT(int_b),
        .LOOKUP(lookup_b), .BUSY(busy_b), .OVERRUN(ovr_b), .FRAME_CNT(frame_b),
        .LED_R(ledr_b), .LED_G(ledg_b), .LED_B(ledb_b));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_last = 0;
    int t_upd  = 0;
    bit sel    = 1'b0;

    // Reference model state per instance (index = sel).
    int m_phase [2];
    int m_frame [2];
    bit m_ovr   [2];
    bit m_wait  [2];

    logic        o_int, o_busy, o_ovr, o_ledr, o_ledg, o_ledb;
    logic [15:0] o_lookup, o_frame;

    always_comb begin
        o_int    = sel ? int_b  : int_a;
        o_busy   = sel ? busy_b : busy_a;
        o_ovr    = sel ? ovr_b  : ovr_a;
        o_ledr   = sel ? ledr_b : ledr_a;
        o_ledg   = sel ? ledg_b : ledg_a;
        o_ledb   = sel ? ledb_b : ledb_a;
        o_lookup = sel ? {15'd0, lookup_b} : {14'd0, lookup_a};
        o_frame  = sel ? {14'd0, frame_b}  : frame_a;
    end

    function automatic int np_of(bit s);
        return s ? 2 : 4;
    endfunction

    function automatic int fmod_of(bit s);
        return s ? 4 : 65536;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (dut %0d cyc %0d): observed %0h expected %0h", tag, sel, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic toggle();
        if (sel) sclk_b = ~sclk_b;
        else     sclk_a = ~sclk_a;
        t_last = cyc;
    endtask

    task automatic model_reset(input bit s);
        m_phase[s] = 0;
        m_frame[s] = 0;
        m_ovr[s]   = 1'b0;
        m_wait[s]  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_int"},    o_int,    32'd0);
        chk({tag, "_lookup"}, o_lookup, 32'd0);
        chk({tag, "_busy"},   o_busy,   32'd0);
        chk({tag, "_ovr"},    o_ovr,    32'd0);
        chk({tag, "_frame"},  o_frame,  32'd0);
        chk({tag, "_ledr"},   o_ledr,   32'd1);
        chk({tag, "_ledg"},   o_ledg,   32'd1);
        chk({tag, "_ledb"},   o_ledb,   32'd1);
    endtask

    // First SCLK transition of a burst; optionally asserts CLR_OVR on the rise edge.
    task automatic start_burst(input bit clr_at_rise);
        toggle();
        tick();
        tick();
        chk("busy_lag", o_busy, 32'd0);
        if (clr_at_rise) begin
            if (sel) clr_b = 1'b1;
            else     clr_a = 1'b1;
        end
        tick();
        clr_a = 1'b0;
        clr_b = 1'b0;
        if (m_wait[sel]) m_ovr[sel] = 1'b1;
        m_wait[sel]  = 1'b0;
        m_phase[sel] = (m_phase[sel] + 1) % np_of(sel);
        chk("busy_rise",   o_busy,   32'd1);
        chk("rise_lookup", o_lookup, 32'd0);
        chk("rise_int",    o_int,    32'd0);
        chk("rise_ovr",    o_ovr,    32'(m_ovr[sel]));
        chk("rise_frame",  o_frame,  32'(m_frame[sel]));
    endtask

    // Remaining transitions of a burst, random gaps well below IDLE.
    task automatic more_edges(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(3, 20)) tick();
            toggle();
        end
    endtask

    task automatic wait_update();
        tick_until(t_last + IDLE + 2);
        chk("pre_upd_busy",   o_busy,   32'd1);
        chk("pre_upd_lookup", o_lookup, 32'd0);
        tick();
        chk("upd_busy",   o_busy,   32'd0);
        chk("upd_lookup", o_lookup, 32'(m_phase[sel]));
        chk("upd_ledb",   o_ledb,   32'd1);
        t_upd       = cyc;
        m_wait[sel] = 1'b1;
    endtask

    task automatic wait_int();
        tick_until(t_upd + DELAY - 1);
        chk("pre_int", o_int, 32'd0);
        tick();
        m_frame[sel] = (m_frame[sel] + 1) % fmod_of(sel);
        m_wait[sel]  = 1'b0;
        chk("int_rise", o_int,   32'd1);
        chk("int_ledr", o_ledr,  32'd0);
        chk("frame",    o_frame, 32'(m_frame[sel]));
        tick();
        chk("int_after", o_int, sel ? 32'd0 : 32'd1);
    endtask

    task automatic full_frame(input int n_edges);
        start_burst(1'b0);
        more_edges(n_edges - 1);
        wait_update();
        wait_int();
    endtask

    task automatic clear_overrun();
        chk("ovr_before_clr", o_ovr, 32'd1);
        if (sel) clr_b = 1'b1;
        else     clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        clr_b = 1'b0;
        m_ovr[sel] = 1'b0;
        chk("ovr_cleared", o_ovr, 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        sclk_a = 1'b0; sclk_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        model_reset(1'b0);
        model_reset(1'b1);
        repeat (3) tick();
        rst_a = 1'b1; rst_b = 1'b1;

        // 1: reset state with SCLK static for 1000 cycles.
        repeat (1000) tick();
        sel = 1'b0; check_idle_outputs("reset_a");
        sel = 1'b1; check_idle_outputs("reset_b");

        // 2: three 16-edge bursts on instance A, level INT, LOOKUP 1,2,3.
        sel = 1'b0;
        for (int f = 0; f < 3; f++) begin
            full_frame(16);
            repeat ($urandom_range(10, 60)) tick();
            chk("int_level_hold", o_int, 32'd1);
        end
        chk("frames_three", o_frame, 32'd3);

        // 3: burst 100 cycles into WAIT aborts the pending INT.
        start_burst(1'b0);
        more_edges(15);
        wait_update();
        tick_until(t_upd + 100);
        start_burst(1'b0);
        chk("abort_ovr", o_ovr, 32'd1);
        more_edges(15);
        wait_update();
        wait_int();
        clear_overrun();

        // 4: instance B, pulse INT after a single burst (LOOKUP=1).
        sel = 1'b1;
        full_frame(2 * $urandom_range(2, 8));
        chk("pulse_frame", o_frame, 32'd1);

        // 5: reset at cycle 150 of WAIT discards the pending INT.
        start_burst(1'b0);
        more_edges(2 * $urandom_range(1, 8) - 1);
        wait_update();
        tick_until(t_upd + 150);
        rst_b = 1'b0;
        tick();
        model_reset(1'b1);
        check_idle_outputs("midwait_rst");
        rst_b = 1'b1;
        repeat (300) tick();
        chk("no_int_after_rst",   o_int,   32'd0);
        chk("no_frame_after_rst", o_frame, 32'd0);

        // 6: FCW=2 wrap over four frames, then a rise in the delay-done cycle.
        for (int f = 0; f < 4; f++) begin
            full_frame(2 * $urandom_range(1, 8));
        end
        chk("frame_wrapped", o_frame, 32'd0);
        start_burst(1'b0);
        more_edges(2 * $urandom_range(1, 8) - 1);
        wait_update();
        tick_until(t_upd + DELAY - 3);
        start_burst(1'b1);
        chk("done_clash_int",   o_int,   32'd0);
        chk("done_clash_ovr",   o_ovr,   32'd1);
        chk("done_clash_frame", o_frame, 32'd0);
        more_edges(2 * $urandom_range(1, 8) - 1);
        wait_update();
        wait_int();
        clear_overrun();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
